// File: rtl/arb_request_gen.sv
// Client-side request queue and grant checker for a 4-way round-robin arbiter.
// Optional per-channel starvation watchdog is built when ARB_REQ_WATCHDOG_EN is defined.
module arb_request_gen #(
  parameter int CNT_W        = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         push,
  output logic [3:0]         req,
  input  logic [3:0]         gnt,
  output logic [3:0]         full,
  output logic [4*CNT_W-1:0] pend,
  output logic [3:0]         ovf,
  output logic               err_gnt,
  output logic [1:0]         err_code,
  output logic [3:0]         starve
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt [4];
  logic [3:0]       lg;
  logic [3:0]       push_acc;
  logic             gnt_multi;
  logic             gnt_unreq;
  logic             gnt_idle;
  logic             err_now;
  logic [1:0]       code_now;

  // req/full are pure decodes of the counter registers, so gnt never reaches req
  always_comb begin
    req  = 4'd0;
    full = 4'd0;
    pend = '0;
    for (int i = 0; i < 4; i++) begin
      req[i]                 = (cnt[i] != '0);
      full[i]                = (cnt[i] == CNT_MAX);
      pend[i*CNT_W +: CNT_W] = cnt[i];
    end
  end

  always_comb begin
    gnt_multi = ((gnt & (gnt - 4'd1)) != 4'd0);
    gnt_unreq = ((gnt & ~req) != 4'd0);
    gnt_idle  = (req != 4'd0) && (gnt == 4'd0);
    err_now   = gnt_multi | gnt_unreq | gnt_idle;
    code_now  = 2'd0;
    if (gnt_multi)      code_now = 2'd1;
    else if (gnt_unreq) code_now = 2'd2;
    else if (gnt_idle)  code_now = 2'd3;
    // an illegal grant cycle retires nothing
    lg       = err_now ? 4'd0 : (gnt & req);
    push_acc = push & (~full | lg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
      ovf      <= 4'd0;
      err_gnt  <= 1'b0;
      err_code <= 2'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push_acc[i] && !lg[i])      cnt[i] <= cnt[i] + CNT_ONE;
        else if (!push_acc[i] && lg[i]) cnt[i] <= cnt[i] - CNT_ONE;
      end
      ovf <= ovf | (push & full & ~lg);
      if (err_now) err_gnt <= 1'b1;
      if (err_now && !err_gnt) err_code <= code_now;
    end
  end

`ifdef ARB_REQ_WATCHDOG_EN
  localparam int              WD_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(STARVE_LIMIT);
  localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

  logic [WD_W-1:0] wait_cnt [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (lg[i] || !req[i])          wait_cnt[i] <= '0;
        else if (wait_cnt[i] != WD_MAX) wait_cnt[i] <= wait_cnt[i] + WD_ONE;
      end
    end
  end

  always_comb begin
    starve = 4'd0;
    for (int i = 0; i < 4; i++) starve[i] = (wait_cnt[i] >= WD_MAX);
  end
`else
  assign starve = 4'd0;
`endif

endmodule
